// File: rtl/pc_bpred.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit direction counters.
// Optional PC_PERF_EN adds fetch/redirect cycle counters.
module pc_bpred #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BTB_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pcn,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target
`ifdef PC_PERF_EN
    ,
    output logic [31:0]           perf_fetch,
    output logic [31:0]           perf_redirect
`endif
);
    localparam int IDX  = $clog2(BTB_DEPTH);
    localparam int TAGW = ADDR_WIDTH - 2 - IDX;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid  [BTB_DEPTH];
    logic [1:0]            r_ctr    [BTB_DEPTH];
    logic [TAGW-1:0]       r_tag    [BTB_DEPTH];
    logic [ADDR_WIDTH-1:0] r_target [BTB_DEPTH];

    logic [IDX-1:0]  w_idx;
    logic [TAGW-1:0] w_tag;
    logic            w_hit;
    logic [IDX-1:0]  w_upd_idx;
    logic [TAGW-1:0] w_upd_tag;
    logic            w_upd_hit;
    logic            w_unused;

    assign w_idx = r_pc[IDX+1:2];
    assign w_tag = r_pc[ADDR_WIDTH-1:IDX+2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_upd_idx = upd_pc[IDX+1:2];
    assign w_upd_tag = upd_pc[ADDR_WIDTH-1:IDX+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // Byte offset of the branch address never takes part in lookup.
    assign w_unused = &{1'b0, upd_pc[1:0]};

    assign pc          = r_pc;
    assign pcn         = r_pc + ADDR_WIDTH'(4);
    assign pred_taken  = w_hit && r_ctr[w_idx][1];
    assign pred_target = pred_taken ? r_target[w_idx] : pcn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'd1;
            end
        end else begin
            if (redirect)
                r_pc <= redirect_pc;
            else if (en)
                r_pc <= pred_target;

            if (upd_valid) begin
                if (upd_taken) begin
                    r_valid[w_upd_idx] <= 1'b1;
                    if (!w_upd_hit)
                        r_ctr[w_upd_idx] <= 2'd2;
                    else if (r_ctr[w_upd_idx] != 2'd3)
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
                end else if (w_upd_hit && r_ctr[w_upd_idx] != 2'd0) begin
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
                end
            end
        end
    end

    // Tag and target are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
        end
    end

`ifdef PC_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (en && !redirect)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (redirect)
                r_perf_redirect <= r_perf_redirect + 32'd1;
        end
    end

    assign perf_fetch    = r_perf_fetch;
    assign perf_redirect = r_perf_redirect;
`endif

endmodule

// File: tb/tb_pc_bpred.sv
// Scoreboard bench for pc_bpred: directed test-plan sequence, then random traffic
// against an address-level BTB model.
module tb_pc_bpred;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, redirect = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic [31:0] redirect_pc = '0, upd_pc = '0, upd_target = '0;
    logic [31:0] pc, pcn, pred_target;
    logic        pred_taken;
`ifdef PC_PERF_EN
    logic [31:0] perf_fetch, perf_redirect;
`endif

    pc_bpred #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .BTB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .pc(pc), .pcn(pcn),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target)
`ifdef PC_PERF_EN
        , .perf_fetch(perf_fetch), .perf_redirect(perf_redirect)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc, pcn, tgt, pf, pr;
        logic        pt;
    } exp_t;
    exp_t q[$];

    // Reference model: each slot remembers the word address of the branch it holds.
    logic [31:0] m_pc;
    bit          m_v    [DEPTH];
    logic [29:0] m_line [DEPTH];
    logic [31:0] m_tgt  [DEPTH];
    int          m_ctr  [DEPTH];
    logic [31:0] m_pf, m_pr;

    function automatic void model_reset();
        m_pc = 32'h0;
        m_pf = '0;
        m_pr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0;
            m_ctr[i] = 1;
        end
    endfunction

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic model_pt(input logic [31:0] a);
        int s = slot(a);
        return m_v[s] && (m_line[s] == a[31:2]) && (m_ctr[s] >= 2);
    endfunction

    function automatic logic [31:0] model_tgt(input logic [31:0] a);
        return model_pt(a) ? m_tgt[slot(a)] : a + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; applies inputs for one cycle, returns at the next falling edge.
    task automatic step(input logic e, input logic r, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg);
        exp_t        x;
        logic [31:0] nxt;
        int          s;
        bit          hit;
        x.pc  = m_pc;
        x.pcn = m_pc + 32'd4;
        x.pt  = model_pt(m_pc);
        x.tgt = model_tgt(m_pc);
        x.pf  = m_pf;
        x.pr  = m_pr;
        q.push_back(x);
        en = e; redirect = r; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        @(posedge clk);
        nxt = r ? rpc : (e ? model_tgt(m_pc) : m_pc);
        if (e && !r) m_pf = m_pf + 1;
        if (r) m_pr = m_pr + 1;
        if (uv) begin
            s = slot(upc);
            hit = m_v[s] && (m_line[s] == upc[31:2]);
            if (ut && hit) begin
                m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                m_tgt[s] = utg;
            end else if (ut) begin
                m_v[s] = 1; m_line[s] = upc[31:2]; m_tgt[s] = utg; m_ctr[s] = 2;
            end else if (hit) begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end
        end
        m_pc = nxt;
        @(negedge clk);
        en = 0; redirect = 0; upd_valid = 0;
    endtask

    task automatic adv(); step(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic hold(); step(0, 0, 0, 0, 0, 0, 0); endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("sb_pc", pc, x.pc);
                chk("sb_pcn", pcn, x.pcn);
                chk("sb_pred_taken", {31'b0, pred_taken}, {31'b0, x.pt});
                chk("sb_pred_target", pred_target, x.tgt);
`ifdef PC_PERF_EN
                chk("sb_perf_fetch", perf_fetch, x.pf);
                chk("sb_perf_redirect", perf_redirect, x.pr);
`endif
            end
        end
    end

    initial begin : driver
        logic [31:0] rpc, upc, utg;
        logic        e, r, uv, ut;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_pred", {31'b0, pred_taken}, 32'h0);
        chk("reset_tgt", pred_target, 32'h4);

        adv(); chk("seq_pc4", pc, 32'h4);
        adv(); chk("seq_pc8", pc, 32'h8);
        adv(); chk("seq_pcC", pc, 32'hC);

        step(1, 0, 0, 1, 32'h10, 1, 32'h80);
        chk("train_pc", pc, 32'h10);
        chk("train_pred", {31'b0, pred_taken}, 32'h1);
        chk("train_tgt", pred_target, 32'h80);
        adv(); chk("follow_pred", pc, 32'h80);

        step(0, 1, 32'h10, 1, 32'h10, 0, 0);
        chk("hyst_nt_pred", {31'b0, pred_taken}, 32'h0);
        step(0, 0, 0, 1, 32'h10, 1, 32'h80);
        step(0, 0, 0, 1, 32'h10, 1, 32'h80);
        chk("hyst_sat_pred", {31'b0, pred_taken}, 32'h1);
        step(0, 0, 0, 1, 32'h10, 0, 0);
        chk("hyst_weak_pred", {31'b0, pred_taken}, 32'h1);

        step(0, 0, 0, 1, 32'h50, 1, 32'h300);
        chk("evict_pred", {31'b0, pred_taken}, 32'h0);
        chk("evict_tgt", pred_target, 32'h14);
        step(0, 1, 32'h50, 0, 0, 0, 0);
        chk("alias_hit_pred", {31'b0, pred_taken}, 32'h1);
        chk("alias_hit_tgt", pred_target, 32'h300);

        step(0, 1, 32'h200, 0, 0, 0, 0);
        chk("redir_stall_pc", pc, 32'h200);
        for (int i = 0; i < 4; i++) begin
            hold();
            chk("hold_pc", pc, 32'h200);
        end

        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        chk("wrap_pcn", pcn, 32'h0);
        adv(); chk("wrap_pc", pc, 32'h0);

        // Asynchronous reset between edges while a redirect and update are pending.
        en = 1; redirect = 1; redirect_pc = 32'h400;
        upd_valid = 1; upd_pc = 32'h50; upd_taken = 1; upd_target = 32'h500;
        #2 rst = 1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_pred", {31'b0, pred_taken}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        en = 0; redirect = 0; upd_valid = 0;
        rst = 0;
        chk("post_rst_pc", pc, 32'h0);
        for (int i = 0; i < 5; i++) adv();
        step(0, 1, 32'h50, 0, 0, 0, 0);
        step(0, 1, 32'h50, 0, 0, 0, 0);
        chk("post_rst_redir", pc, 32'h50);
        chk("training_lost", {31'b0, pred_taken}, 32'h0);
`ifdef PC_PERF_EN
        chk("perf_fetch5", perf_fetch, 32'd5);
        chk("perf_redirect2", perf_redirect, 32'd2);
`endif

        for (int n = 0; n < 1500; n++) begin
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                2:       rpc = 32'($urandom_range(0, 255));
                default: rpc = 32'($urandom_range(0, 63)) << 2;
            endcase
            uv  = ($urandom_range(0, 9) < 4);
            upc = ($urandom_range(0, 2) == 0) ? m_pc
                : ((32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)));
            ut  = ($urandom_range(0, 9) < 6);
            utg = 32'($urandom_range(0, 63)) << 2;
            step(e, r, rpc, uv, upc, ut, utg);
        end

        #3;
        if (q.size() != 0) chk("sb_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_bpred.md
# pc_bpred

Parametrised fetch-address generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the head of the IF stage and holds the architectural fetch PC. Each cycle it predicts the next fetch address from the BTB. It accepts a redirect from EX on misprediction, and BTB training updates from resolved branches and jumps.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- RESET_PC, 0, PC value loaded on reset.
- BTB_DEPTH, 16, number of BTB entries; power of two, ≥2. IDX = log2(BTB_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  fetch advance; 0 = stall, PC holds.
- pc  out  ADDR_WIDTH  current fetch address (registered).
- pcn  out  ADDR_WIDTH  pc + 4, mod 2^ADDR_WIDTH.
- pred_taken  out  1  BTB predicts taken for pc (combinational from pc).
- pred_target  out  ADDR_WIDTH  predicted next PC: BTB target if pred_taken, else pcn.
- redirect  in  1  EX misprediction; forces next PC.
- redirect_pc  in  ADDR_WIDTH  correct next PC when redirect=1.
- upd_valid  in  1  resolved control-transfer instruction in EX.
- upd_pc  in  ADDR_WIDTH  address of that instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_WIDTH  actual taken target.

## Operation
- BTB entry: valid(1), tag(ADDR_WIDTH-2-IDX), target(ADDR_WIDTH), ctr(2).
- Index = addr[IDX+1:2]; tag = addr[ADDR_WIDTH-1:IDX+2]; addr[1:0] ignored for lookup.
- Lookup on pc: hit = valid && tag match. pred_taken = hit && ctr[1].
- Next PC priority: redirect → redirect_pc; else en → pred_target; else hold pc.
- Redirect applies even when en=0.
- Update, on upd_valid at the edge, for the entry at upd_pc's index:
  - taken, tag hit: ctr saturating +1 (max 3); target ← upd_target.
  - taken, miss or invalid: allocate. valid=1, tag, target ← upd_target, ctr=2 (weakly taken). Any previous occupant is evicted.
  - not taken, tag hit: ctr saturating −1 (min 0); entry stays valid.
  - not taken, miss: no change.
- Update is independent of en and redirect.
- No alignment check: redirect_pc and targets are used as given, including low bits.

## Timing
- Reset (async, immediate): pc=RESET_PC, pcn=RESET_PC+4, all valid=0, all ctr=1. pred_taken=0 and pred_target=pcn until trained.
- PC latency: redirect, advance or hold decided in cycle n is visible on pc in cycle n+1.
- BTB: lookup is combinational, read-before-write. An update in cycle n to the index pc currently reads affects prediction from cycle n+1 only.
- Redirect and update in the same cycle: both take effect; pc ← redirect_pc.
- pcn and pred_target wrap modulo 2^ADDR_WIDTH (0xFFFFFFFC+4 → 0x0).
- rst asserted mid-operation: state cleared immediately, regardless of redirect/upd_valid. First advance after release fetches from RESET_PC.

## Configuration
- PC_PERF_EN defined: adds outputs perf_fetch (32, counts cycles where en=1 && redirect=0) and perf_redirect (32, counts cycles with redirect=1).
  - Both counters reset to 0 and wrap at 2^32.
- PC_PERF_EN undefined: the two ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then en=1 for 3 cycles, BTB empty → pc 0x0, 0x4, 0x8, 0xC; pred_taken=0 throughout.
- Train: upd_valid with upd_pc=0x10, taken, target 0x80 → after pc reaches 0x10, pred_taken=1, pred_target=0x80, next pc=0x80.
- Counter hysteresis on entry 0x10:
  - one not-taken update (ctr 2→1) → pred_taken=0.
  - two taken updates → ctr=3 → pred_taken=1.
  - one not-taken update (ctr 3→2) → still pred_taken=1.
- Alias eviction, BTB_DEPTH=16: train 0x10→0x80, then train 0x50 taken (same index) → lookup of 0x10 misses (pred_taken=0); 0x50 hits.
- Priority: en=0 with redirect=1, redirect_pc=0x200 → pc=0x200 next cycle. en=0 without redirect → pc holds for 4 cycles.
- Async reset asserted between edges during redirect → pc=RESET_PC immediately; prior training lost.
- With PC_PERF_EN: 5 advance cycles plus 2 redirect cycles → perf_fetch=5, perf_redirect=2.
